// File: rtl/ram_pkg.sv
// Shared widths, default depth and FSM encoding for the two-port RAM arbiter.
package ram_pkg;
    localparam int unsigned RAM_DW        = 33;
    localparam int unsigned RAM_AW        = 33;
    localparam int unsigned RAM_DEPTH_DEF = 1024;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the pointer remembers which port was granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    // last_q = 1 means port 1 won most recently, so port 0 wins the next tie
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end
endmodule

// File: rtl/ram_arb.sv
// Arbitrates two request/response masters onto one RAM port, one transaction in flight
// at a time (IDLE -> ACCESS -> RESP); out-of-range addresses never reach the RAM.
module ram_arb
    import ram_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [RAM_AW-1:0] m0_req_adr,
    input  logic [RAM_DW-1:0] m0_req_din,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [RAM_DW-1:0] m0_rsp_data,
    output logic              m0_rsp_err,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [RAM_AW-1:0] m1_req_adr,
    input  logic [RAM_DW-1:0] m1_req_din,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [RAM_DW-1:0] m1_rsp_data,
    output logic              m1_rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_adr,
    output logic [RAM_DW-1:0] ram_din,
    input  logic [RAM_DW-1:0] ram_dout
);
    state_e            state_q, state_d;
    logic [1:0]        gnt;
    logic              accept;
    logic              owner_q;
    logic              we_q;
    logic [RAM_AW-1:0] adr_q;
    logic [RAM_DW-1:0] din_q;
    logic [RAM_DW-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              in_range;
    logic              rsp_ready_own;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({m1_req_valid, m0_req_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    assign m0_req_ready = (state_q == StIdle) && gnt[0];
    assign m1_req_ready = (state_q == StIdle) && gnt[1];
    assign accept       = (state_q == StIdle) && (gnt != 2'b00);

    assign in_range = adr_q < RAM_AW'(RAM_DEPTH);
    assign ram_en   = (state_q == StAccess) && in_range;
    assign ram_we   = ram_en && we_q;
    assign ram_adr  = adr_q;
    assign ram_din  = din_q;

    assign rsp_ready_own = owner_q ? m1_rsp_ready : m0_rsp_ready;
    assign m0_rsp_valid  = (state_q == StResp) && !owner_q;
    assign m1_rsp_valid  = (state_q == StResp) && owner_q;
    assign m0_rsp_data   = rsp_data_q;
    assign m1_rsp_data   = rsp_data_q;
    assign m0_rsp_err    = rsp_err_q;
    assign m1_rsp_err    = rsp_err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (rsp_ready_own) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            din_q   <= '0;
        end else if (accept) begin
            owner_q <= gnt[1];
            we_q    <= gnt[1] ? m1_req_we  : m0_req_we;
            adr_q   <= gnt[1] ? m1_req_adr : m0_req_adr;
            din_q   <= gnt[1] ? m1_req_din : m0_req_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (state_q == StAccess) begin
            rsp_data_q <= (in_range && !we_q) ? ram_dout : '0;
            rsp_err_q  <= !in_range;
        end
    end
endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb with a 1024-word behavioural RAM behind it.
module tb_ram_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [32:0] m0_req_adr, m0_req_din;
    logic        m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
    logic [32:0] m0_rsp_data;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [32:0] m1_req_adr, m1_req_din;
    logic        m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
    logic [32:0] m1_rsp_data;
    logic        ram_en, ram_we;
    logic [32:0] ram_adr, ram_din, ram_dout;

    int vectors = 0;
    int miscompares = 0;

    logic [32:0] mem [1024];
    bit          mem_loaded = 1'b0;

    always #5 clk = ~clk;

    ram_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_we    (m0_req_we),
        .m0_req_adr   (m0_req_adr),
        .m0_req_din   (m0_req_din),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (m0_rsp_ready),
        .m0_rsp_data  (m0_rsp_data),
        .m0_rsp_err   (m0_rsp_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_we    (m1_req_we),
        .m1_req_adr   (m1_req_adr),
        .m1_req_din   (m1_req_din),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (m1_rsp_ready),
        .m1_rsp_data  (m1_rsp_data),
        .m1_rsp_err   (m1_rsp_err),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_adr      (ram_adr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    // Word i powers up as 0x1_0000_0000 | i
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 33'h1_0000_0000 | 33'(i);
            mem_loaded <= 1'b1;
        end else if (ram_en && ram_we && ram_adr < 33'd1024) begin
            mem[ram_adr[9:0]] <= ram_din;
        end
    end

    assign ram_dout = (ram_adr < 33'd1024) ? mem[ram_adr[9:0]] : 33'h0;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Drives one request from an idle negedge and records what happens; returns at idle.
    task automatic run_txn(input int p, input logic we, input logic [32:0] adr, din,
                           output logic acc_ok, output logic en_s, we_s,
                           output logic [32:0] data_s, output logic err_s, rsp_ok);
        acc_ok = 1'b0; en_s = 1'b0; we_s = 1'b0; data_s = '0; err_s = 1'b0; rsp_ok = 1'b0;
        if (p == 0) begin
            m0_req_valid = 1'b1; m0_req_we = we; m0_req_adr = adr; m0_req_din = din;
        end else begin
            m1_req_valid = 1'b1; m1_req_we = we; m1_req_adr = adr; m1_req_din = din;
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            if ((p == 0) ? m0_req_ready : m1_req_ready) begin
                acc_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        if (!acc_ok) return;
        en_s = ram_en;
        we_s = ram_we;
        @(negedge clk);
        rsp_ok = (p == 0) ? (m0_rsp_valid && !m1_rsp_valid) : (m1_rsp_valid && !m0_rsp_valid);
        data_s = (p == 0) ? m0_rsp_data : m1_rsp_data;
        err_s  = (p == 0) ? m0_rsp_err : m1_rsp_err;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_adr = '0; m0_req_din = '0;
        m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_adr = '0; m1_req_din = '0;
        m0_rsp_ready = 1'b1; m1_rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({ram_en, ram_we} !== 2'b00) begin
            miscompares++; $display("FAIL reset_ram_ctl: got %b want 00", {ram_en, ram_we});
        end
        vectors++;
        if (ram_adr !== 33'h0 || ram_din !== 33'h0) begin
            miscompares++; $display("FAIL reset_ram_bus: got %h/%h want 0/0", ram_adr, ram_din);
        end
        vectors++;
        if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_rsp_flags: got %b want 0000",
                     {m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err});
        end
        vectors++;
        if (m0_rsp_data !== 33'h0 || m1_rsp_data !== 33'h0) begin
            miscompares++;
            $display("FAIL reset_rsp_data: got %h/%h want 0/0", m0_rsp_data, m1_rsp_data);
        end
        vectors++;
        if ({m0_req_ready, m1_req_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 00", {m0_req_ready, m1_req_ready});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        logic acc, en, we, err, ok;
        logic [32:0] d;
        run_txn(0, 1'b1, 33'd5, 33'h1_2345_6789, acc, en, we, d, err, ok);
        vectors++;
        if ({acc, en, we, ok} !== 4'b1111) begin
            miscompares++; $display("FAIL wr_flow acc/en/we/rsp: got %b want 1111", {acc, en, we, ok});
        end
        vectors++;
        if (d !== 33'h0 || err !== 1'b0) begin
            miscompares++; $display("FAIL wr_rsp data/err: got %h/%b want 0/0", d, err);
        end
        vectors++;
        if (ram_we !== 1'b0 || ram_en !== 1'b0) begin
            miscompares++; $display("FAIL wr_we_one_cycle: got %b%b want 00", ram_en, ram_we);
        end
        vectors++;
        if (mem[5] !== 33'h1_2345_6789) begin
            miscompares++; $display("FAIL wr_mem5: got %h want 123456789", mem[5]);
        end
        run_txn(0, 1'b0, 33'd5, 33'h0, acc, en, we, d, err, ok);
        vectors++;
        if ({acc, en, we, ok} !== 4'b1101) begin
            miscompares++; $display("FAIL rd_flow acc/en/we/rsp: got %b want 1101", {acc, en, we, ok});
        end
        vectors++;
        if (d !== 33'h1_2345_6789 || err !== 1'b0) begin
            miscompares++; $display("FAIL rd_rsp data/err: got %h/%b want 123456789/0", d, err);
        end
    endtask

    task automatic test_out_of_range;
        logic acc, en, we, err, ok;
        logic [32:0] d;
        run_txn(1, 1'b0, 33'd1024, 33'h0, acc, en, we, d, err, ok);
        vectors++;
        if ({acc, en, ok} !== 3'b101 || d !== 33'h0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_rd_1024 acc/en/rsp data err: got %b %h %b want 101 0 1",
                     {acc, en, ok}, d, err);
        end
        run_txn(0, 1'b1, 33'h1_0000_0005, 33'h77, acc, en, we, d, err, ok);
        vectors++;
        if ({acc, en, we, ok} !== 4'b1001 || d !== 33'h0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_wr_high acc/en/we/rsp data err: got %b %h %b want 1001 0 1",
                     {acc, en, we, ok}, d, err);
        end
        vectors++;
        if (mem[5] !== 33'h1_2345_6789) begin
            miscompares++; $display("FAIL oor_no_alias: got %h want 123456789", mem[5]);
        end
        run_txn(1, 1'b0, 33'd1023, 33'h0, acc, en, we, d, err, ok);
        vectors++;
        if ({acc, en, ok} !== 3'b111 || d !== 33'h1_0000_03ff || err !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_rd_1023 acc/en/rsp data err: got %b %h %b want 111 1000003ff 0",
                     {acc, en, ok}, d, err);
        end
    endtask

    task automatic test_round_robin;
        int cnt [2];
        int g;
        logic [32:0] exp_adr;
        test_reset();
        cnt[0] = 0; cnt[1] = 0;
        m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_adr = 33'd10;
        m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_adr = 33'd20;
        for (int t = 0; t < 8; t++) begin
            #1;
            if (m0_req_ready && !m1_req_ready) g = 0;
            else if (m1_req_ready && !m0_req_ready) g = 1;
            else g = -1;
            vectors++;
            if (g != (t % 2)) begin
                miscompares++; $display("FAIL rr_grant[%0d]: got %0d want %0d", t, g, t % 2);
            end
            if (g < 0) break;
            exp_adr = ((g == 0) ? 33'd10 : 33'd20) + 33'(cnt[g]);
            @(negedge clk);
            vectors++;
            if (ram_adr !== exp_adr || ram_en !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_access[%0d]: got %h/%b want %h/1", t, ram_adr, ram_en, exp_adr);
            end
            cnt[g]++;
            if (g == 0) begin
                m0_req_adr = 33'd10 + 33'(cnt[0]);
                if (cnt[0] == 4) m0_req_valid = 1'b0;
            end else begin
                m1_req_adr = 33'd20 + 33'(cnt[1]);
                if (cnt[1] == 4) m1_req_valid = 1'b0;
            end
            @(negedge clk);
            vectors++;
            if ({m0_rsp_valid, m1_rsp_valid} !== ((g == 0) ? 2'b10 : 2'b01) ||
                ((g == 0) ? m0_rsp_data : m1_rsp_data) !== (33'h1_0000_0000 | exp_adr)) begin
                miscompares++;
                $display("FAIL rr_rsp[%0d]: got v=%b d=%h want port %0d d=%h", t,
                         {m0_rsp_valid, m1_rsp_valid}, (g == 0) ? m0_rsp_data : m1_rsp_data,
                         g, 33'h1_0000_0000 | exp_adr);
            end
            @(negedge clk);
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
    endtask

    task automatic test_hold_rsp;
        m1_rsp_ready = 1'b0;
        m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_adr = 33'd7;
        #1;
        vectors++;
        if (m1_req_ready !== 1'b1) begin
            miscompares++; $display("FAIL hold_accept: got %b want 1", m1_req_ready);
        end
        @(negedge clk);
        m1_req_valid = 1'b0;
        m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_adr = 33'd8;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (m1_rsp_valid !== 1'b1 || m1_rsp_data !== 33'h1_0000_0007 || m1_rsp_err !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_rsp[%0d]: got %b %h %b want 1 100000007 0", k,
                         m1_rsp_valid, m1_rsp_data, m1_rsp_err);
            end
            vectors++;
            if (m0_req_ready !== 1'b0 || m0_rsp_valid !== 1'b0 || ram_en !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_blocked[%0d]: got %b%b%b want 000", k,
                         m0_req_ready, m0_rsp_valid, ram_en);
            end
            @(negedge clk);
        end
        m1_rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (m1_rsp_valid !== 1'b0 || m0_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release: got v=%b rdy0=%b want 0 1", m1_rsp_valid, m0_req_ready);
        end
        @(negedge clk);
        m0_req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_data !== 33'h1_0000_0008) begin
            miscompares++;
            $display("FAIL hold_next_rsp: got %b %h want 1 100000008", m0_rsp_valid, m0_rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_access;
        m0_req_valid = 1'b1; m0_req_we = 1'b1; m0_req_adr = 33'd9; m0_req_din = 33'h0_aaaa_5555;
        @(negedge clk);
        m0_req_valid = 1'b0;
        vectors++;
        if (ram_we !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre_we: got %b want 1", ram_we);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ram_en, ram_we, m0_rsp_valid, m1_rsp_valid} !== 4'b0000 || ram_adr !== 33'h0) begin
            miscompares++;
            $display("FAIL rst_abort: got %b adr=%h want 0000 adr=0",
                     {ram_en, ram_we, m0_rsp_valid, m1_rsp_valid}, ram_adr);
        end
        @(negedge clk);
        vectors++;
        if (mem[9] !== 33'h1_0000_0009 || m0_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_write: got %h v=%b want 100000009 v=0", mem[9], m0_rsp_valid);
        end
        rst_n = 1'b1;
        m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_adr = 33'd2;
        m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_adr = 33'd3;
        #1;
        vectors++;
        if ({m0_req_ready, m1_req_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_tie_port0: got %b want 10", {m0_req_ready, m1_req_ready});
        end
        @(negedge clk);
        m0_req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_data !== 33'h1_0000_0002) begin
            miscompares++;
            $display("FAIL rst_p0_rsp: got %b %h want 1 100000002", m0_rsp_valid, m0_rsp_data);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (m1_req_ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_p1_next: got %b want 1", m1_req_ready);
        end
        @(negedge clk);
        m1_req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (m1_rsp_valid !== 1'b1 || m1_rsp_data !== 33'h1_0000_0003) begin
            miscompares++;
            $display("FAIL rst_p1_rsp: got %b %h want 1 100000003", m1_rsp_valid, m1_rsp_data);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_round_robin();
        test_hold_rsp();
        test_reset_in_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 1024, meaning the number of valid RAM words; addresses >= RAM_DEPTH are out of range.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports m0_req_valid input 1 and m0_req_ready output 1, the port-0 request handshake.
REQ-005 SHALL have ports m0_req_we input 1, m0_req_adr input 33 and m0_req_din input 33, the port-0 write flag, word address and write data.
REQ-006 SHALL have ports m0_rsp_valid output 1 and m0_rsp_ready input 1, the port-0 response handshake.
REQ-007 SHALL have ports m0_rsp_data output 33 and m0_rsp_err output 1, the port-0 read data and out-of-range flag.
REQ-008 SHALL have port-1 signals m1_* identical in name suffix, direction and width to REQ-004..REQ-007.
REQ-009 SHALL have ports ram_en output 1, ram_we output 1, ram_adr output 33 and ram_din output 33, driving the downstream RAM.
REQ-010 SHALL have port ram_dout, input, 33, the RAM combinational read data for ram_adr.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS and RESP, with one transaction outstanding at most.
REQ-012 In IDLE, the arbiter SHALL assert exactly one mX_req_ready, combinationally, for the granted port with mX_req_valid=1; all readies SHALL be 0 in ACCESS and RESP.
REQ-013 Grant SHALL be round-robin: if both ports are valid, the port not granted last wins; a lone valid port always wins; after reset, port 0 wins a tie.
REQ-014 On an accept (valid & ready in IDLE), the arbiter SHALL latch we, adr, din and the owner, and go to ACCESS next cycle.
REQ-015 In ACCESS, the arbiter SHALL drive ram_adr and ram_din from the latched values and drive ram_en=1 and ram_we=latched we, only when adr < RAM_DEPTH.
REQ-016 In ACCESS, the arbiter SHALL register ram_dout into the response data for reads, or 0 for writes; then it SHALL go to RESP.
REQ-017 For an out-of-range adr in ACCESS, the arbiter SHALL keep ram_en=0 and ram_we=0, set err=1 and set data=0; the RAM SHALL see no access.
REQ-018 In RESP, the arbiter SHALL assert owner's rsp_valid with stable data and err until rsp_ready=1, then return to IDLE next cycle; the non-owner's rsp_valid SHALL stay 0.
REQ-019 Latency: accept at cycle N means RAM access at N+1 and rsp_valid at N+2; peak throughput is one transaction per 3 cycles.
REQ-020 Outside ACCESS, ram_en and ram_we SHALL be 0, and ram_adr and ram_din SHALL hold their last latched values.
REQ-021 mX_req_* SHALL be ignored while mX_req_ready=0; a requester is expected to hold valid and payload until accepted.
REQ-022 rsp_ready asserted while rsp_valid=0 SHALL have no effect.

Reset
REQ-023 On rst_n=0, the block SHALL asynchronously force state IDLE, last-grant pointer = port 1 (so port 0 wins next), all rsp_valid=0, rsp_data=0, rsp_err=0, ram_en=0, ram_we=0, ram_adr=0 and ram_din=0.
REQ-024 Reset during ACCESS or RESP SHALL abort the transaction with no response delivered and no further RAM write.

Structure
REQ-025 Shared package ram_pkg SHALL hold RAM_DW=33, RAM_AW=33, RAM_DEPTH_DEF=1024 and the FSM state encoding.
REQ-026 The round-robin pointer and grant logic SHALL be a sub-module rr_arb2, with inputs req[1:0] and advance and output gnt[1:0].

Verification
REQ-027 Port-0 write adr=5 din=0x1_2345_6789, then read adr=5 -> ram_we=1 for one cycle at N+1, write response data=0 and err=0, read response data=0x1_2345_6789 at N+2.
REQ-028 Both ports valid each idle cycle, 4 reads each -> grants alternate 0,1,0,1,...; responses go only to the owning port.
REQ-029 Read adr=1024 -> ram_en stays 0, rsp_err=1, rsp_data=0.
REQ-030 Hold rsp_ready=0 for 5 cycles -> rsp_valid, data and err stable, no new accept, FSM stays in RESP.
REQ-031 rst_n low during ACCESS of a write -> ram_we=0 immediately, all rsp_valid=0, next tied request is granted to port 0.
